// File: rtl/ct_timing_pkg.sv
// Shared timing constants, field codes and pointer-op helpers for the A&R control sequencer.
package ct_timing_pkg;

  typedef enum logic [2:0] {
    FLD_P  = 3'b000,
    FLD_M  = 3'b001,
    FLD_X  = 3'b010,
    FLD_W  = 3'b011,
    FLD_WP = 3'b100,
    FLD_MS = 3'b101,
    FLD_XS = 3'b110,
    FLD_S  = 3'b111
  } field_e;

  localparam int unsigned T_SYNC_FIRST = 45;
  localparam int unsigned T_SYNC_LAST  = 54;
  localparam int unsigned T_READY      = 44;
  localparam int unsigned T_LAST       = 55;
  localparam int unsigned DIGITS_DEF   = 14;

  localparam logic [1:0] TYPE_MISC  = 2'b00;
  localparam logic [1:0] TYPE_ARITH = 2'b10;

  // Pointer ops: I[1:0]=00 and I[3:2]=11; I[4] selects load vs step, I[5] selects direction.
  localparam logic [9:0] PTR_OP_MASK  = 10'b00_0000_1111;
  localparam logic [9:0] PTR_OP_MATCH = 10'b00_0000_1100;

  function automatic logic [3:0] ptr_next(input logic [9:0] i, input logic [3:0] p,
                                          input logic [3:0] p_max);
    logic [3:0] r;
    r = p;
    if ((i & PTR_OP_MASK) == PTR_OP_MATCH) begin
      if (!i[4]) begin
        if (i[9:6] <= p_max) r = i[9:6];
      end else if (!i[5]) begin
        r = (p == '0) ? p_max : p - 4'd1;
      end else begin
        r = (p == p_max) ? '0 : p + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ws_field_decode.sv
// Maps an arithmetic field code and the current pointer to the inclusive digit range lo..hi.
module ws_field_decode
  import ct_timing_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic [2:0] fld,
  input  logic [3:0] p,
  output logic [3:0] lo,
  output logic [3:0] hi
);

  localparam logic [3:0] D_MS = 4'(DIGITS - 1);

  always_comb begin
    lo = '0;
    hi = '0;
    case (field_e'(fld))
      FLD_P:  begin lo = p;     hi = p;     end
      FLD_M:  begin lo = 4'd3;  hi = 4'd12; end
      FLD_X:  begin lo = 4'd0;  hi = 4'd2;  end
      FLD_W:  begin lo = 4'd0;  hi = D_MS;  end
      FLD_WP: begin lo = 4'd0;  hi = p;     end
      FLD_MS: begin lo = 4'd3;  hi = D_MS;  end
      FLD_XS: begin lo = 4'd2;  hi = 4'd2;  end
      FLD_S:  begin lo = D_MS;  hi = D_MS;  end
      default: begin lo = '0;   hi = '0;    end
    endcase
  end

endmodule

// File: rtl/ct_ws_sequencer.sv
// Word-time sequencer: fetches one instruction per word, serialises it on is/sync,
// executes the previous one by driving ws, and maintains the digit pointer P.
module ct_ws_sequencer
  import ct_timing_pkg::*;
#(
  parameter int unsigned WORD_BITS  = T_LAST + 1,
  parameter int unsigned DIGITS     = DIGITS_DEF,
  parameter int unsigned SYNC_FIRST = T_SYNC_FIRST,
  parameter logic [9:0]  NOP_INST   = 10'h000
) (
  input  logic       cph2,
  input  logic       rst,
  input  logic       inst_valid,
  input  logic [9:0] inst,
  output logic       inst_ready,
  output logic       sync,
  output logic       is,
  output logic       ws,
  output logic [5:0] word_time,
  output logic [3:0] p_out
);

  localparam logic [5:0] T_END   = 6'(WORD_BITS - 1);
  localparam logic [5:0] T_RDY   = 6'(SYNC_FIRST - 1);
  localparam logic [5:0] T_SF    = 6'(SYNC_FIRST);
  localparam logic [5:0] T_SL    = 6'(SYNC_FIRST + 9);
  localparam logic [3:0] P_MAX   = 4'(DIGITS - 1);

  logic [5:0] t_q;
  logic [9:0] shift_q;
  logic [9:0] fetch_q;
  logic [9:0] exec_q;
  logic [3:0] p_q;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       win;
  logic [3:0] digit;

  assign win   = (t_q >= T_SF) && (t_q <= T_SL);
  assign digit = t_q[5:2];

  always_ff @(posedge cph2) begin
    if (rst) begin
      t_q     <= '0;
      shift_q <= NOP_INST;
      fetch_q <= NOP_INST;
      exec_q  <= NOP_INST;
      p_q     <= '0;
    end else begin
      t_q <= (t_q == T_END) ? '0 : t_q + 6'd1;
      // fetch_q keeps the whole word for the T55 hand-off; shift_q is consumed LSB first.
      if (t_q == T_RDY) begin
        fetch_q <= inst_valid ? inst : NOP_INST;
        shift_q <= inst_valid ? inst : NOP_INST;
      end else if (win) begin
        shift_q <= {1'b0, shift_q[9:1]};
      end
      if (t_q == T_END) begin
        exec_q <= fetch_q;
        p_q    <= ptr_next(exec_q, p_q, P_MAX);
      end
    end
  end

  // P only moves on the T55 edge, so p_q is already the value sampled at T0 of this word.
  ws_field_decode #(
    .DIGITS(DIGITS)
  ) u_decode (
    .fld(exec_q[4:2]),
    .p  (p_q),
    .lo (lo),
    .hi (hi)
  );

  assign inst_ready = (t_q == T_RDY);
  assign sync       = win;
  assign is         = win & shift_q[0];
  assign ws         = (exec_q[1:0] == TYPE_ARITH) && (digit >= lo) && (digit <= hi);
  assign word_time  = t_q;
  assign p_out      = p_q;

endmodule

// File: tb/tb_ct_ws_sequencer.sv
// Scoreboard bench for ct_ws_sequencer: per-word expectations from a behavioural model,
// checked cycle by cycle by an independent monitor.
module tb_ct_ws_sequencer;

  localparam logic [9:0] NOP = 10'h000;

  logic       cph2 = 1'b0;
  logic       rst;
  logic       inst_valid;
  logic [9:0] inst;
  logic       inst_ready, sync, is, ws;
  logic [5:0] word_time;
  logic [3:0] p_out;

  ct_ws_sequencer #(
    .WORD_BITS (56),
    .DIGITS    (14),
    .SYNC_FIRST(45),
    .NOP_INST  (NOP)
  ) dut (
    .cph2      (cph2),
    .rst       (rst),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_ready(inst_ready),
    .sync      (sync),
    .is        (is),
    .ws        (ws),
    .word_time (word_time),
    .p_out     (p_out)
  );

  always #5 cph2 = ~cph2;

  typedef struct {
    logic [55:0] ws_mask;
    logic [9:0]  is_word;
    logic [3:0]  p;
  } word_exp_t;

  typedef struct {
    logic       valid;
    logic [9:0] inst;
    bit         abort;
  } stim_t;

  word_exp_t exp_q[$];
  stim_t     stim[$];
  int        checks   = 0;
  int        failures = 0;

  function automatic logic [55:0] ws_mask_of(input logic [9:0] i, input int p);
    logic [55:0] m;
    int lo, hi;
    m = '0;
    if (i[1:0] != 2'b10) return m;
    case (i[4:2])
      3'd0: begin lo = p;  hi = p;  end
      3'd1: begin lo = 3;  hi = 12; end
      3'd2: begin lo = 0;  hi = 2;  end
      3'd3: begin lo = 0;  hi = 13; end
      3'd4: begin lo = 0;  hi = p;  end
      3'd5: begin lo = 3;  hi = 13; end
      3'd6: begin lo = 2;  hi = 2;  end
      default: begin lo = 13; hi = 13; end
    endcase
    for (int b = 4 * lo; b <= 4 * hi + 3; b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic int p_after(input logic [9:0] i, input int p);
    if (i[1:0] != 2'b00 || i[3:2] != 2'b11) return p;
    if (!i[4]) return (int'(i[9:6]) < 14) ? int'(i[9:6]) : p;
    if (!i[5]) return (p == 0) ? 13 : p - 1;
    return (p == 13) ? 0 : p + 1;
  endfunction

  function automatic stim_t mk(input logic v, input logic [9:0] i, input bit ab);
    stim_t s;
    s.valid = v;
    s.inst  = i;
    s.abort = ab;
    return s;
  endfunction

  function automatic logic [9:0] rand_inst();
    logic [9:0] r;
    int unsigned kind;
    r    = 10'($urandom);
    kind = $urandom_range(0, 2);
    if (kind == 0) r[1:0] = 2'b10;
    else if (kind == 1) r[3:0] = 4'b1100;
    return r;
  endfunction

  // Monitor: compares every cycle against the word record popped at T0.
  initial begin : monitor
    int        c = 0;
    bit        prev_rst = 1'b1;
    bit        have = 1'b0;
    word_exp_t rec;
    logic [13:0] act, expv;
    forever begin
      @(negedge cph2);
      act = {word_time, p_out, inst_ready, sync, is, ws};
      if (rst && prev_rst) begin
        checks++;
        if (act !== 14'd0) begin
          failures++;
          $display("FAIL reset_state got=%h exp=%h", act, 14'd0);
        end
        c = 0;
      end else begin
        if (c == 0) begin
          have = (exp_q.size() != 0);
          if (have) rec = exp_q.pop_front();
          else begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 exp=1 record");
          end
        end
        if (have) begin
          expv = {6'(c), rec.p, 1'(c == 44), 1'(c >= 45 && c <= 54),
                  (c >= 45 && c <= 54) ? rec.is_word[c - 45] : 1'b0, rec.ws_mask[c]};
          checks++;
          if (act !== expv) begin
            failures++;
            $display("FAIL word_cycle T=%0d got=%h exp=%h (time,p,rdy,sync,is,ws)", c, act, expv);
          end
        end
        c = (c == 55) ? 0 : c + 1;
      end
      prev_rst = rst;
    end
  end

  // Driver and reference model.
  initial begin : driver
    int         m_p;
    logic [9:0] m_exec;
    logic [9:0] fetched;
    bit         aborted;
    word_exp_t  rec;

    rst = 1'b1; inst_valid = 1'b0; inst = '0;

    stim.push_back(mk(1'b1, 10'b1010110110, 1'b0));
    stim.push_back(mk(1'b0, 10'b1111111111, 1'b0));
    stim.push_back(mk(1'b1, 10'b00000_011_10, 1'b0));
    stim.push_back(mk(1'b1, 10'b00000_111_10, 1'b0));
    stim.push_back(mk(1'b1, 10'b0101_0_0_11_00, 1'b0));
    stim.push_back(mk(1'b1, 10'b00000_000_10, 1'b0));
    stim.push_back(mk(1'b1, 10'b00000_100_10, 1'b0));
    stim.push_back(mk(1'b1, 10'b0000_0_0_11_00, 1'b0));
    stim.push_back(mk(1'b1, 10'b0000_0_1_11_00, 1'b0));
    stim.push_back(mk(1'b1, 10'b0000_1_1_11_00, 1'b0));
    stim.push_back(mk(1'b1, 10'b1111_0_0_11_00, 1'b0));
    stim.push_back(mk(1'b0, 10'b0000_0_1_11_00, 1'b0));
    stim.push_back(mk(1'b0, 10'b00000_011_10, 1'b0));
    stim.push_back(mk(1'b1, 10'b0111_0_0_11_00, 1'b0));
    stim.push_back(mk(1'b1, 10'b00000_011_10, 1'b1));
    stim.push_back(mk(1'b1, 10'b00000_011_10, 1'b0));
    for (int k = 0; k < 40; k++)
      stim.push_back(mk(1'($urandom_range(0, 3) != 0), rand_inst(), 1'($urandom_range(0, 19) == 0)));

    repeat (3) @(posedge cph2);
    #1 rst = 1'b0;
    m_p = 0;
    m_exec = NOP;

    foreach (stim[w]) begin
      fetched     = stim[w].valid ? stim[w].inst : NOP;
      rec.ws_mask = ws_mask_of(m_exec, m_p);
      rec.is_word = fetched;
      rec.p       = 4'(m_p);
      exp_q.push_back(rec);
      aborted = 1'b0;
      for (int c = 0; c < 56; c++) begin
        if (stim[w].abort && c == 30) begin
          rst = 1'b1;
          repeat (3) @(posedge cph2);
          #1 rst = 1'b0;
          aborted = 1'b1;
          break;
        end
        if (c == 44) begin
          inst_valid = stim[w].valid;
          inst       = stim[w].inst;
        end else begin
          inst_valid = 1'($urandom_range(0, 1));
          inst       = 10'($urandom);
        end
        @(posedge cph2);
        #1;
      end
      if (aborted) begin
        m_p    = 0;
        m_exec = NOP;
      end else begin
        m_p    = p_after(m_exec, m_p);
        m_exec = fetched;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ct_ws_sequencer.md
Name: ct_ws_sequencer

Overview:
- Timing and word-select sequencer that drives the A&R arithmetic chip's serial control inputs: sync, is (instruction serial) and ws (word select).
- Keeps the 56-bit-time word counter and accepts 10-bit instructions from the fetch unit through a valid/ready handshake.
- Shifts each instruction out on is while sync is high, then generates ws for that instruction's field during the following word.
- Owns the 4-bit digit pointer P and executes the pointer instructions.

Parameters:
- WORD_BITS, 56, bit times per word cycle (14 BCD digits x 4 bits).
- DIGITS, 14, digits per word.
- SYNC_FIRST, 45, first bit time of the sync/is window (window is SYNC_FIRST..SYNC_FIRST+9).
- NOP_INST, 10'h000, instruction substituted when no valid instruction is offered.

Ports:
- cph2  in  1  system bit clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- inst_valid  in  1  fetch unit offers inst.
- inst  in  10  instruction I[9:0].
- inst_ready  out  1  one-cycle pulse at T44; transfer occurs when inst_valid & inst_ready.
- sync  out  1  high for T45..T54.
- is  out  1  instruction serial bit, LSB first, T45..T54.
- ws  out  1  word select for the instruction executing this word.
- word_time  out  6  current bit time T, 0..55.
- p_out  out  4  current pointer value, 0..13.

Behaviour:
- Reset values, held while rst=1 and in the first cycle after release:
  - T=0, sync=0, is=0, ws=0, inst_ready=0, P=0.
  - Shift, fetch and execute instruction registers = NOP_INST.
- Reset mid-word aborts the word. The first word after reset executes NOP_INST (ws stays 0).
- Word counter T:
  - Increments every cycle.
  - 55 wraps to 0.
- inst_ready:
  - Is 1 exactly when T=44.
  - If inst_valid=1 at T44, inst is captured into the shift register; otherwise NOP_INST is captured.
  - inst is ignored at all other T.
- Serialization:
  - sync=1 for T in 45..54 only.
  - During that window, is = shift[T-45].
  - is=0 outside the window.
- Pipeline:
  - At T55, the shifted instruction moves to the execute register.
  - It is executed during the whole next word (T0..T55).
  - Per word: one instruction shifts while the previous one executes.
- ws generation:
  - ws is decoded from registered state only; there is no combinational path from inst or inst_valid.
  - If the execute instruction has I[1:0]≠2'b10 (not arithmetic), ws=0 for the whole word.
  - Otherwise the field code I[4:2] selects digits lo..hi, and ws=1 for T in 4·lo .. 4·hi+3:
    - 000 P: lo=hi=P.
    - 001 M: 3..12.
    - 010 X: 0..2.
    - 011 W: 0..13.
    - 100 WP: 0..P.
    - 101 MS: 3..13.
    - 110 XS: 2..2.
    - 111 S: 13..13.
  - For fields P and WP, P is sampled at T0 of the execute word, so a pointer change later in that word does not alter ws.
- Pointer instructions (execute register I[1:0]=2'b00 and I[3:2]=2'b11):
  - I[4]=0: P=I[9:6]. Values 14 and 15 are ignored (P unchanged).
  - I[4]=1, I[5]=0: P=P-1. 0 wraps to 13.
  - I[4]=1, I[5]=1: P=P+1. 13 wraps to 0.
  - The update takes effect at T55 of the execute word, so it is first visible to the next executing instruction.
  - All other instructions leave P unchanged.
- Simultaneous events:
  - At T55 the execute-register load and the pointer update both occur.
  - The pointer update uses the outgoing execute instruction.
- rst has priority over every other event.

Decomposition:
- Package ct_timing_pkg holds:
  - Field-code constants (FLD_P .. FLD_S).
  - T_SYNC_FIRST, T_SYNC_LAST, T_READY=44, T_LAST=55.
  - Instruction-type constants: TYPE_MISC=2'b00, TYPE_ARITH=2'b10.
  - Pointer-op decode masks.
- Sub-module ws_field_decode (combinational): inputs are the field code and latched P; outputs are digit lo and hi (4 bits each).
- The top level compares T[5:2] against lo/hi.

Test Plan:
- Reset: hold rst 3 cycles mid-word at T=30 → next cycle word_time=0, sync/is/ws/inst_ready=0, p_out=0. The next full word has ws=0.
- Serialization: inst=10'b1010110110 valid at T44 → sync=1 for T45..54. is sequence LSB first = 0,1,1,0,1,1,0,1,0,1. No handshake → is all zero.
- Field W: arith inst I[4:2]=011 → ws=1 for T0..55 of the following word. Field S → ws=1 only for T52..55.
- Pointer then P/WP: execute P=5 (I=10'b0101_0_0_11_00). Then field P → ws=1 at T20..23 only. Then field WP → ws=1 at T0..23.
- Pointer wrap: P=0 then P-1 → p_out=13 after T55. P+1 → 0. P=15 → p_out unchanged.
- Idle fetch: inst_valid=0 for two words → inst_ready pulses at T44 each word, NOP executes (ws=0), P unchanged.
